// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS transfers and returns rdata/status.
// Latency: accept at edge T -> SETUP T+1, ACCESS T+2, rsp_valid from T+3; each pready=0 cycle adds one.
// Backpressure: one transfer in flight; cmd_ready only in IDLE, response held in RESP until rsp_ready.
module apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    // APB
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic [1:0]        pslverr
);

    // Counter only has to reach TIMEOUT-1; keep at least one bit so a disabled timeout still elaborates.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Ready only while idle and out of reset, so nothing is accepted during reset or in flight.
    assign cmd_ready   = (state == IDLE) && presetn;

    // Last permitted stalled ACCESS cycle; pready=1 in the same cycle still completes the transfer.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        // Read data is kept even when the slave flags an error.
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= (|pslverr) ? ERR_SLAVE : ERR_OK;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= ERR_TIMEOUT;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scoreboard of expected responses, behavioural APB slave, protocol monitor.
// Latency: responses checked against the expected accept-to-rsp_valid cycle count.
// Backpressure: rsp_ready is held low in one scenario to check response hold and command blocking.
module tb_apb_master;

    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic [1:0]  pslverr = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] slv_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    int          slv_wait  = 0;
    logic [1:0]  slv_err   = 2'b00;
    bit          slv_stuck = 1'b0;
    int          acc_n     = 0;

    // SETUP-phase snapshot taken by xfer one cycle after accept
    logic        snap_psel, snap_penable, snap_pwrite;
    logic [11:0] snap_paddr;
    logic [31:0] snap_pwdata;

    apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TO)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    // Behavioural slave: drives pready/prdata/pslverr at negedge; garbage whenever the DUT must ignore them.
    always @(negedge pclk) begin
        if (psel && penable) begin
            if (!slv_stuck && acc_n >= slv_wait) begin
                pready  = 1'b1;
                pslverr = slv_err;
                if (pwrite) begin
                    prdata = $urandom;
                    if (slv_err == 2'b00) slv_mem[paddr] = pwdata;
                end else begin
                    prdata = slv_mem[paddr];
                end
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 2'b11;
            end
            acc_n++;
        end else begin
            acc_n   = 0;
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 2'($urandom);
        end
    end

    // Protocol monitor: SETUP must be followed by ACCESS, stalled ACCESS must hold the bus.
    logic        p_ok = 1'b0;
    logic        p_psel, p_pen, p_pwrite;
    logic [11:0] p_addr;
    logic [31:0] p_wdata;
    always @(posedge pclk) begin
        #2;
        if (p_ok && presetn && p_psel && !p_pen) begin
            total++;
            if (!(psel === 1'b1 && penable === 1'b1 && paddr === p_addr && pwrite === p_pwrite)) begin
                bad++;
                $display("FAIL setup_to_access: psel=%b penable=%b paddr=%h required psel=1 penable=1 paddr=%h",
                         psel, penable, paddr, p_addr);
            end
        end
        if (p_ok && presetn && p_psel && p_pen && !pready && !rsp_valid) begin
            total++;
            if ({psel, penable, pwrite, paddr, pwdata} !== {2'b11, p_pwrite, p_addr, p_wdata}) begin
                bad++;
                $display("FAIL wait_stable: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required 1 1 %b %h %h",
                         psel, penable, pwrite, paddr, pwdata, p_pwrite, p_addr, p_wdata);
            end
        end
        p_ok     = presetn;
        p_psel   = psel;
        p_pen    = penable;
        p_pwrite = pwrite;
        p_addr   = paddr;
        p_wdata  = pwdata;
    end

    // Drive one command, push its expectation, and wait (bounded) for rsp_valid. No comparisons here.
    task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d, input int wt,
                        input logic [1:0] se, input bit stuck,
                        output logic [31:0] rd, output logic [1:0] er, output int lat);
        exp_t e;
        int   n;
        slv_wait  = wt;
        slv_err   = se;
        slv_stuck = stuck;
        if (stuck) begin
            e.rdata = 32'h0;
            e.err   = 2'b10;
            e.lat   = TO + 2;
        end else begin
            e.err   = (se != 2'b00) ? 2'b01 : 2'b00;
            e.rdata = w ? 32'h0 : ref_mem[a];
            e.lat   = 3 + wt;
            if (w && se == 2'b00) ref_mem[a] = d;
        end
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge pclk); #1;
            n++;
        end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 12'($urandom);
        cmd_wdata = $urandom;
        snap_psel    = psel;
        snap_penable = penable;
        snap_pwrite  = pwrite;
        snap_paddr   = paddr;
        snap_pwdata  = pwdata;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge pclk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset();
        presetn   = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        total++;
        if ({psel, penable, pwrite, paddr, pwdata} !== 47'h0) begin
            bad++;
            $display("FAIL reset_bus: got %h required 0", {psel, penable, pwrite, paddr, pwdata});
        end
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== 35'h0) begin
            bad++;
            $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_rdata, rsp_err});
        end
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        total++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: cmd_ready=%b psel=%b required 1 0", cmd_ready, psel);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        exp_t        e;
        xfer(1'b1, 12'h010, 32'hDEADBEEF, 0, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if ({snap_psel, snap_penable, snap_pwrite, snap_paddr, snap_pwdata} !== {3'b101, 12'h010, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wr_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required 1 0 1 010 deadbeef",
                     snap_psel, snap_penable, snap_pwrite, snap_paddr, snap_pwdata);
        end
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL wr_rsp: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        total++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            bad++;
            $display("FAIL wr_bus_idle: psel=%b penable=%b required 0 0", psel, penable);
        end
        @(posedge pclk); #1;
        xfer(1'b0, 12'h010, 32'h0, 0, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (snap_pwrite !== 1'b0 || snap_paddr !== 12'h010 || snap_psel !== 1'b1 || snap_penable !== 1'b0) begin
            bad++;
            $display("FAIL rd_setup: pwrite=%b paddr=%h psel=%b penable=%b required 0 010 1 0",
                     snap_pwrite, snap_paddr, snap_psel, snap_penable);
        end
        total++;
        if (rd !== 32'hDEADBEEF || rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL rd_rsp: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        exp_t        e;
        slv_mem[12'h004] = 32'h12345678;
        ref_mem[12'h004] = 32'h12345678;
        xfer(1'b0, 12'h004, 32'h0, 3, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL wait3: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_slverr();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        exp_t        e;
        xfer(1'b1, 12'hFFF, 32'hA5A5_0F0F, 0, 2'b01, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL slverr_wr: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
        xfer(1'b0, 12'h000, 32'h0, 1, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL after_err_rd: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
        // pslverr=10 still counts as an error, and read data is still returned
        xfer(1'b0, 12'h020, 32'h0, 0, 2'b10, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL slverr_rd: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        exp_t        e;
        xfer(1'b0, 12'h040, 32'h0, 0, 2'b00, 1'b1, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL timeout: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        total++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            bad++;
            $display("FAIL timeout_bus: psel=%b penable=%b required 0 0", psel, penable);
        end
        @(posedge pclk); #1;
        // pready arriving on the last allowed cycle beats the timeout
        xfer(1'b0, 12'h044, 32'h0, TO - 1, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL pready_wins: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
        xfer(1'b0, 12'h048, 32'h0, 0, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL after_timeout_rd: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        exp_t        e;
        rsp_ready = 1'b0;
        xfer(1'b0, 12'h0A8, 32'h0, 0, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL bp_rsp: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        cmd_valid = 1'b1;
        cmd_addr  = 12'h0B0;
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk); #1;
            total++;
            if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel} !== {1'b1, e.rdata, e.err, 2'b00}) begin
                bad++;
                $display("FAIL bp_hold: cycle=%0d rsp_valid=%b rdata=%h err=%b cmd_ready=%b psel=%b required 1 %h %b 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel, e.rdata, e.err);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
        exp_t        e;
        slv_stuck = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h0C0;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        total++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_access: psel=%b penable=%b required 1 1", psel, penable);
        end
        presetn = 1'b0;
        #1;
        total++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset: psel=%b penable=%b rsp_valid=%b cmd_ready=%b required 0 0 0 0",
                     psel, penable, rsp_valid, cmd_ready);
        end
        slv_stuck = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        total++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL mid_release: cmd_ready=%b psel=%b rsp_valid=%b required 1 0 0", cmd_ready, psel, rsp_valid);
        end
        xfer(1'b0, 12'h010, 32'h0, 2, 2'b00, 1'b0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL mid_after_rd: rdata=%h err=%b lat=%0d required %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
        end
        @(posedge pclk); #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_empty: left=%0d required 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] v;
            v = $urandom;
            slv_mem[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_write_read();
        test_wait_states();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns read data and status on a valid/ready response channel.
- Sits between a local controller (e.g. mailbox/DMA sequencer) and one APB slave port with a 12-bit address and 32-bit data.
- Handles pready wait states, pslverr, and an optional access timeout.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, consecutive ACCESS cycles with pready=0 before the transfer is aborted; 0 disables the timeout.

Ports:
- pclk  input  1  clock; all logic on rising edge.
- presetn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  transfer address.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  output  2  00 ok, 01 slave error, 10 timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- pready  input  1  slave ready.
- prdata  input  DATA_W  slave read data.
- pslverr  input  2  slave error; any nonzero value is an error.

Behaviour:
- Reset (async, presetn=0): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout counter all 0. cmd_ready=0 while presetn=0.
- Reset mid-transfer: bus drops to psel=penable=0 immediately; any pending response is discarded.
- All APB outputs and response outputs are registered. cmd_ready is combinational: 1 iff state==IDLE and presetn=1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid & cmd_ready, latch write/addr/wdata into pwrite/paddr/pwdata, set psel=1, penable=0, go to SETUP.
  - Otherwise psel=penable=0; paddr/pwrite/pwdata hold their last values.
- SETUP: exactly one cycle. Next edge sets penable=1, clears the timeout counter, goes to ACCESS.
- ACCESS, pready=1 (completion):
  - Next edge: psel=penable=0, rsp_valid=1, go to RESP.
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_err = 01 if pslverr!=0, else 00. Read data is still captured on a slave error.
- ACCESS, pready=0: hold all APB outputs stable; increment the counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 while pready=0, the next edge aborts: psel=penable=0, rsp_valid=1, rsp_err=10, rsp_rdata=0, go to RESP.
  - pready=1 in that same cycle wins over the timeout.
- RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready. On rsp_valid & rsp_ready, the next edge clears rsp_valid and goes to IDLE. No new command is accepted while in RESP.
- Latency: command accept at edge T gives SETUP in cycle T+1, ACCESS in T+2, and rsp_valid from T+3 (zero wait states). Each pready=0 cycle adds one.
- Throughput: at most one outstanding transfer. Back-to-back minimum spacing is 4 cycles per transfer with rsp_ready tied to 1.
- Inputs prdata/pslverr are sampled only in ACCESS with pready=1; values at other times are ignored.

Test Plan:
- Write then read: cmd write addr 0x010 data 0xDEADBEEF, then read 0x010, with a responding slave (pready=1) → APB write visible as SETUP (psel=1, penable=0) then ACCESS. Read returns rsp_rdata=0xDEADBEEF, rsp_err=00; rsp_valid exactly 3 cycles after each accept.
- Wait states: read 0x004 with the slave holding pready=0 for 3 ACCESS cycles, prdata=0x12345678 → paddr/psel/penable stable throughout; rsp_valid 6 cycles after accept; rsp_rdata=0x12345678.
- Slave error: write 0xFFF with pslverr=2'b01 at completion → rsp_err=01, rsp_rdata=0. Following read to 0x000 proceeds normally with rsp_err=00.
- Timeout: TIMEOUT=16, pready stuck 0 → after 16 ACCESS cycles psel=penable=0, rsp_err=10, rsp_rdata=0. Then pready=1 and a new read completes normally.
- Backpressure: rsp_ready=0 for 5 cycles after a read → rsp fields stable, cmd_ready=0, psel=0. After the handshake, cmd_ready=1 next cycle.
- Reset mid-ACCESS: drop presetn during a waited read → psel, penable, rsp_valid immediately 0. After release, state is IDLE and cmd_ready=1.
